// File: rtl/nibbler_acc_pkg.sv
// ---------------------------------------------------------------------------
// nibbler_acc_pkg
// Shared definitions for the nibble processor accumulator path.
//   - OP_* localparams : 3-bit operation codes driven by the control unit
//   - acc_op_e         : enum view of the same codes for decoders/debug
//   - acc_op_name      : helper that maps an op code to a short mnemonic
// ---------------------------------------------------------------------------
package nibbler_acc_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // Enum members carry an E_ prefix so they do not collide with the
    // plain localparams above; the encodings are identical.
    typedef enum logic [2:0] {
        E_HOLD = 3'b000,
        E_LOAD = 3'b001,
        E_ADD  = 3'b010,
        E_SUB  = 3'b011,
        E_NAND = 3'b100,
        E_PUSH = 3'b101,
        E_POP  = 3'b110,
        E_CLR  = 3'b111
    } acc_op_e;

    function automatic string acc_op_name(input logic [2:0] code);
        case (code)
            OP_HOLD: return "HOLD";
            OP_LOAD: return "LOAD";
            OP_ADD:  return "ADD";
            OP_SUB:  return "SUB";
            OP_NAND: return "NAND";
            OP_PUSH: return "PUSH";
            OP_POP:  return "POP";
            default: return "CLR";
        endcase
    endfunction

endpackage

// File: rtl/acc_lifo.sv
// ---------------------------------------------------------------------------
// acc_lifo
// LIFO shadow stack for the accumulator.
//   clk, rst      : clock, synchronous active-high reset (empties the stack)
//   push, pop     : requests (never both at once); illegal ones are ignored
//   wdata         : value stored on a legal push
//   rdata         : current top-of-stack (valid while not empty)
//   full, empty   : registered occupancy flags
//   depth         : registered occupancy count
//   err           : one-cycle pulse after a push-when-full / pop-when-empty
// ---------------------------------------------------------------------------
module acc_lifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] ONE_V   = DW'(1);
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [DW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          err_q, err_d;
    logic          we;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    // The next free slot is the occupancy count; the top entry sits one
    // below it. Subtracting in AW bits wraps correctly when the stack is
    // completely full of a power-of-two depth.
    assign wr_idx  = count_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);

    // Occupancy update and overflow/underflow detection. Flags are derived
    // from the next count so full/empty/depth always agree with each other.
    always_comb begin
        count_d = count_q;
        err_d   = 1'b0;
        we      = 1'b0;
        if (push) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                we      = 1'b1;
                count_d = count_q + ONE_V;
            end
        end else if (pop) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - ONE_V;
            end
        end
        full_d  = (count_d == DEPTH_V);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Storage is never cleared; reset only resets the pointer, so stale
    // contents are unreachable afterwards.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[wr_idx] <= wdata;
        end
    end

    assign rdata = empty_q ? '0 : mem[top_idx];
    assign full  = full_q;
    assign empty = empty_q;
    assign depth = count_q;
    assign err   = err_q;

endmodule

// File: rtl/acc_stack_unit.sv
// ---------------------------------------------------------------------------
// acc_stack_unit
// Parametrised accumulator with carry/zero flags and a LIFO shadow stack.
//   clk, rst   : clock, synchronous active-high reset (wins over en/op)
//   en, op     : operation enable and 3-bit op code (see nibbler_acc_pkg)
//   in_data    : operand / load value
//   out        : registered accumulator
//   carry      : carry / no-borrow flag, written only by ADD and SUB
//   zero       : registered (out == 0)
//   full/empty/depth : shadow stack occupancy
//   err        : one-cycle pulse after an illegal PUSH or POP
// SAT=1 clamps ADD overflow to all ones and SUB borrow to zero.
// ---------------------------------------------------------------------------
module acc_stack_unit
    import nibbler_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             in_data,
    output logic [WIDTH-1:0]             out,
    output logic                         carry,
    output logic                         zero,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             push, pop;
    logic [WIDTH-1:0] stack_top;
    logic             stack_empty;

    assign push = en && (op == OP_PUSH);
    assign pop  = en && (op == OP_POP);

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (acc_q),
        .rdata (stack_top),
        .full  (full),
        .empty (stack_empty),
        .depth (depth),
        .err   (err)
    );

    assign empty = stack_empty;

    // Both arithmetic results are formed one bit wider so the MSB is the
    // carry-out; SUB uses two's complement so carry=1 means no borrow.
    assign add_full = {1'b0, acc_q} + {1'b0, in_data};
    assign sub_full = {1'b0, acc_q} + {1'b0, ~in_data} + {{WIDTH{1'b0}}, 1'b1};

    // ALU mux. Carry is reported the same in wrap and saturate mode; only
    // the stored accumulator value is clamped. A POP on an empty stack
    // leaves the accumulator alone.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (en) begin
            case (op)
                OP_LOAD: acc_d = in_data;
                OP_ADD: begin
                    carry_d = add_full[WIDTH];
                    if (SAT && add_full[WIDTH]) acc_d = '1;
                    else                        acc_d = add_full[WIDTH-1:0];
                end
                OP_SUB: begin
                    carry_d = sub_full[WIDTH];
                    if (SAT && !sub_full[WIDTH]) acc_d = '0;
                    else                         acc_d = sub_full[WIDTH-1:0];
                end
                OP_NAND: acc_d = ~(acc_q & in_data);
                OP_POP: begin
                    if (!stack_empty) acc_d = stack_top;
                end
                OP_CLR:  acc_d = '0;
                default: acc_d = acc_q;
            endcase
        end
        zero_d = (acc_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign out   = acc_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_acc_stack_unit
// Table-driven bench for acc_stack_unit (WIDTH=4, DEPTH=4). A wrap-mode and a
// saturating instance share the same inputs; the saturating instance's
// accumulator is compared against its own expected column.
// ---------------------------------------------------------------------------
module tb_acc_stack_unit;
    import nibbler_acc_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [3:0] in_data;

    logic [3:0] out_w, out_s;
    logic       carry_w, carry_s;
    logic       zero_w, zero_s;
    logic       full_w, full_s;
    logic       empty_w, empty_s;
    logic [2:0] depth_w, depth_s;
    logic       err_w, err_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] op;
        logic [3:0] din;
        logic [3:0] e_out;
        logic       e_carry;
        logic       e_zero;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_depth;
        logic       e_err;
        logic [3:0] e_sat_out;
    } vec_t;

    vec_t vecs[$];

    acc_stack_unit #(.WIDTH(4), .DEPTH(4), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .op(op), .in_data(in_data),
        .out(out_w), .carry(carry_w), .zero(zero_w), .full(full_w),
        .empty(empty_w), .depth(depth_w), .err(err_w)
    );

    acc_stack_unit #(.WIDTH(4), .DEPTH(4), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .op(op), .in_data(in_data),
        .out(out_s), .carry(carry_s), .zero(zero_s), .full(full_s),
        .empty(empty_s), .depth(depth_s), .err(err_s)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one vector record to the table.
    task automatic addVec(input logic r, input logic e, input logic [2:0] o,
                          input logic [3:0] d, input logic [3:0] eo,
                          input logic ec, input logic ez, input logic ef,
                          input logic ee, input logic [2:0] ed,
                          input logic er, input logic [3:0] eso);
        vec_t v;
        v.rst = r; v.en = e; v.op = o; v.din = d;
        v.e_out = eo; v.e_carry = ec; v.e_zero = ez; v.e_full = ef;
        v.e_empty = ee; v.e_depth = ed; v.e_err = er; v.e_sat_out = eso;
        vecs.push_back(v);
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, then sample 1 unit
    // after the edge.
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [2:0] o, input logic [3:0] d);
        @(negedge clk);
        rst = r; en = e; op = o; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string tag, input int idx,
                              input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h",
                     tag, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkField("out",     idx, {4'b0, out_w},   {4'b0, v.e_out});
        checkField("carry",   idx, {7'b0, carry_w}, {7'b0, v.e_carry});
        checkField("zero",    idx, {7'b0, zero_w},  {7'b0, v.e_zero});
        checkField("full",    idx, {7'b0, full_w},  {7'b0, v.e_full});
        checkField("empty",   idx, {7'b0, empty_w}, {7'b0, v.e_empty});
        checkField("depth",   idx, {5'b0, depth_w}, {5'b0, v.e_depth});
        checkField("err",     idx, {7'b0, err_w},   {7'b0, v.e_err});
        checkField("sat_out", idx, {4'b0, out_s},   {4'b0, v.e_sat_out});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = OP_HOLD; in_data = 4'h0;

        //     rst en op       din   out  c  z  f  e  d  err sat
        // reset held two cycles with a competing LOAD
        addVec(1, 1, OP_LOAD, 4'hA, 4'h0, 0, 1, 0, 1, 0, 0, 4'h0);
        addVec(1, 1, OP_LOAD, 4'hA, 4'h0, 0, 1, 0, 1, 0, 0, 4'h0);
        // arithmetic: 9 + 8 wraps to 1 with carry, saturates to F
        addVec(0, 1, OP_LOAD, 4'h9, 4'h9, 0, 0, 0, 1, 0, 0, 4'h9);
        addVec(0, 1, OP_ADD,  4'h8, 4'h1, 1, 0, 0, 1, 0, 0, 4'hF);
        // subtract with borrow: 3 - 5 = E, saturates to 0
        addVec(0, 1, OP_LOAD, 4'h3, 4'h3, 1, 0, 0, 1, 0, 0, 4'h3);
        addVec(0, 1, OP_SUB,  4'h5, 4'hE, 0, 0, 0, 1, 0, 0, 4'h0);
        // subtract to zero: no borrow
        addVec(0, 1, OP_LOAD, 4'h3, 4'h3, 0, 0, 0, 1, 0, 0, 4'h3);
        addVec(0, 1, OP_SUB,  4'h3, 4'h0, 1, 1, 0, 1, 0, 0, 4'h0);
        // NAND: ~(C & A) = 7, carry held
        addVec(0, 1, OP_LOAD, 4'hC, 4'hC, 1, 0, 0, 1, 0, 0, 4'hC);
        addVec(0, 1, OP_NAND, 4'hA, 4'h7, 1, 0, 0, 1, 0, 0, 4'h7);
        // fill the stack with 1..4
        addVec(0, 1, OP_LOAD, 4'h1, 4'h1, 1, 0, 0, 1, 0, 0, 4'h1);
        addVec(0, 1, OP_PUSH, 4'h0, 4'h1, 1, 0, 0, 0, 1, 0, 4'h1);
        addVec(0, 1, OP_LOAD, 4'h2, 4'h2, 1, 0, 0, 0, 1, 0, 4'h2);
        addVec(0, 1, OP_PUSH, 4'h0, 4'h2, 1, 0, 0, 0, 2, 0, 4'h2);
        addVec(0, 1, OP_LOAD, 4'h3, 4'h3, 1, 0, 0, 0, 2, 0, 4'h3);
        addVec(0, 1, OP_PUSH, 4'h0, 4'h3, 1, 0, 0, 0, 3, 0, 4'h3);
        addVec(0, 1, OP_LOAD, 4'h4, 4'h4, 1, 0, 0, 0, 3, 0, 4'h4);
        addVec(0, 1, OP_PUSH, 4'h0, 4'h4, 1, 0, 1, 0, 4, 0, 4'h4);
        // overflow push, then err drops on the next edge
        addVec(0, 1, OP_PUSH, 4'h0, 4'h4, 1, 0, 1, 0, 4, 1, 4'h4);
        addVec(0, 1, OP_HOLD, 4'h0, 4'h4, 1, 0, 1, 0, 4, 0, 4'h4);
        // drain in LIFO order
        addVec(0, 1, OP_POP,  4'h0, 4'h4, 1, 0, 0, 0, 3, 0, 4'h4);
        addVec(0, 1, OP_POP,  4'h0, 4'h3, 1, 0, 0, 0, 2, 0, 4'h3);
        addVec(0, 1, OP_POP,  4'h0, 4'h2, 1, 0, 0, 0, 1, 0, 4'h2);
        addVec(0, 1, OP_POP,  4'h0, 4'h1, 1, 0, 0, 1, 0, 0, 4'h1);
        // underflow pop
        addVec(0, 1, OP_POP,  4'h0, 4'h1, 1, 0, 0, 1, 0, 1, 4'h1);
        // disabled ADD for three cycles: nothing moves, err clears
        addVec(0, 0, OP_ADD,  4'h5, 4'h1, 1, 0, 0, 1, 0, 0, 4'h1);
        addVec(0, 0, OP_ADD,  4'h5, 4'h1, 1, 0, 0, 1, 0, 0, 4'h1);
        addVec(0, 0, OP_ADD,  4'h5, 4'h1, 1, 0, 0, 1, 0, 0, 4'h1);
        // CLR
        addVec(0, 1, OP_CLR,  4'h9, 4'h0, 1, 1, 0, 1, 0, 0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].din);
            checkOutput(i, vecs[i]);
        end

        // Mid-stack reset: two pushes, then reset empties the stack and
        // the following POP underflows.
        begin
            vec_t v;
            applyStimulus(0, 1, OP_LOAD, 4'h5);
            applyStimulus(0, 1, OP_PUSH, 4'h0);
            applyStimulus(0, 1, OP_PUSH, 4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h5, 1, 0, 0, 0, 3'd2, 0, 4'h5};
            checkOutput(100, v);
            applyStimulus(1, 1, OP_POP, 4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h0, 0, 1, 0, 1, 3'd0, 0, 4'h0};
            checkOutput(101, v);
            applyStimulus(0, 1, OP_POP, 4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h0, 0, 1, 0, 1, 3'd0, 1, 4'h0};
            checkOutput(102, v);
        end

        // POP immediately followed by PUSH reuses the freed slot.
        begin
            vec_t v;
            applyStimulus(0, 1, OP_LOAD, 4'h6);
            applyStimulus(0, 1, OP_PUSH, 4'h0);
            applyStimulus(0, 1, OP_LOAD, 4'h7);
            applyStimulus(0, 1, OP_PUSH, 4'h0);
            applyStimulus(0, 1, OP_POP,  4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h7, 0, 0, 0, 0, 3'd1, 0, 4'h7};
            checkOutput(200, v);
            applyStimulus(0, 1, OP_PUSH, 4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h7, 0, 0, 0, 0, 3'd2, 0, 4'h7};
            checkOutput(201, v);
            applyStimulus(0, 1, OP_CLR,  4'h0);
            applyStimulus(0, 1, OP_POP,  4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h7, 0, 0, 0, 0, 3'd1, 0, 4'h7};
            checkOutput(202, v);
            applyStimulus(0, 1, OP_POP,  4'h0);
            v = '{0, 0, OP_HOLD, 4'h0, 4'h6, 0, 0, 0, 1, 3'd0, 0, 4'h6};
            checkOutput(203, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
